// File: rtl/eth_pause_frame_tx.sv
// Builds 802.3x PAUSE frames (DA..pad, no FCS) byte by byte for the TX MAC between data frames.
// Latency: START one cycle after a pending request sees TxFlow & ~DataFrameActive in IDLE; one byte per TxUsedData.
// Backpressure: the MAC paces bytes with TxUsedData; requests wait in a one-deep pending slot where the last value wins.
module eth_pause_frame_tx #(
    parameter int FRM_LEN = 60
) (
    input  logic        MTxClk,
    input  logic        TxReset_n,
    input  logic [47:0] MAC,
    input  logic        TxFlow,
    input  logic        TxPauseRq,
    input  logic [15:0] TxPauseTV,
    input  logic        DataFrameActive,
    input  logic        TxUsedData,
    input  logic        TxDoneIn,
    input  logic        TxAbortIn,
    output logic        CtrlMux,
    output logic        TxCtrlStartFrm,
    output logic        TxCtrlEndFrm,
    output logic [7:0]  TxCtrlData,
    output logic        CtrlTxDone,
    output logic        PauseRqBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the last byte before the MAC-appended FCS
    localparam logic [5:0] LastByte = 6'(FRM_LEN - 1);

    state_t      state;
    logic        pend;
    logic [15:0] pendTV;
    logic [15:0] frmTV;
    logic [5:0]  byteCnt;
    logic        ctrlTxDoneQ;
    logic        capture;
    logic        launch;
    logic [7:0]  frameByte;

    assign capture = TxPauseRq & TxFlow;
    assign launch  = (state == IDLE) & pend & TxFlow & ~DataFrameActive;

    // Pending request slot; a same-cycle request overrides the launch clear so it stays queued
    always_ff @(posedge MTxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            pend   <= 1'b0;
            pendTV <= 16'h0000;
        end else if (capture) begin
            pend   <= 1'b1;
            pendTV <= TxPauseTV;
        end else if (launch) begin
            pend   <= 1'b0;
        end
    end

    // Frame sequencer: launch, byte stepping, abort handling and completion pulse
    always_ff @(posedge MTxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            state       <= IDLE;
            frmTV       <= 16'h0000;
            byteCnt     <= 6'd0;
            ctrlTxDoneQ <= 1'b0;
        end else begin
            ctrlTxDoneQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= START;
                        frmTV   <= pendTV;
                        byteCnt <= 6'd0;
                    end
                end
                START: begin
                    if (TxAbortIn) begin
                        state <= IDLE;
                    end else if (TxUsedData) begin
                        byteCnt <= 6'd1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (TxAbortIn) begin
                        state <= IDLE;
                    end else if (TxUsedData) begin
                        // Counter parks on the last byte so it never wraps
                        if (byteCnt == LastByte) begin
                            state <= DONE;
                        end else begin
                            byteCnt <= byteCnt + 6'd1;
                        end
                    end
                end
                DONE: begin
                    if (TxDoneIn | TxAbortIn) begin
                        ctrlTxDoneQ <= TxDoneIn;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte map: reserved multicast DA, station SA, MAC-control type, PAUSE opcode, pause time, zero pad
    always_comb begin
        frameByte = 8'h00;
        case (byteCnt)
            6'd0:    frameByte = 8'h01;
            6'd1:    frameByte = 8'h80;
            6'd2:    frameByte = 8'hC2;
            6'd3:    frameByte = 8'h00;
            6'd4:    frameByte = 8'h00;
            6'd5:    frameByte = 8'h01;
            6'd6:    frameByte = MAC[47:40];
            6'd7:    frameByte = MAC[39:32];
            6'd8:    frameByte = MAC[31:24];
            6'd9:    frameByte = MAC[23:16];
            6'd10:   frameByte = MAC[15:8];
            6'd11:   frameByte = MAC[7:0];
            6'd12:   frameByte = 8'h88;
            6'd13:   frameByte = 8'h08;
            6'd14:   frameByte = 8'h00;
            6'd15:   frameByte = 8'h01;
            6'd16:   frameByte = frmTV[15:8];
            6'd17:   frameByte = frmTV[7:0];
            default: frameByte = 8'h00;
        endcase
    end

    assign CtrlMux        = (state != IDLE);
    assign TxCtrlStartFrm = (state == START);
    assign TxCtrlEndFrm   = (state == SEND) && (byteCnt == LastByte);
    assign TxCtrlData     = ((state == START) || (state == SEND)) ? frameByte : 8'h00;
    assign CtrlTxDone     = ctrlTxDoneQ;
    assign PauseRqBusy    = pend | (state != IDLE);

endmodule

// File: tb/tb_eth_pause_frame_tx.sv
// Bench for eth_pause_frame_tx: directed scenarios plus randomized frames against a frame-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The MAC side is emulated with random TxUsedData pacing and random done/abort endings.
module tb_eth_pause_frame_tx;

    localparam int FRM_LEN = 60;

    logic        MTxClk = 1'b0;
    logic        TxReset_n;
    logic [47:0] MAC;
    logic        TxFlow;
    logic        TxPauseRq;
    logic [15:0] TxPauseTV;
    logic        DataFrameActive;
    logic        TxUsedData;
    logic        TxDoneIn;
    logic        TxAbortIn;
    logic        CtrlMux;
    logic        TxCtrlStartFrm;
    logic        TxCtrlEndFrm;
    logic [7:0]  TxCtrlData;
    logic        CtrlTxDone;
    logic        PauseRqBusy;

    eth_pause_frame_tx #(.FRM_LEN(FRM_LEN)) dut (
        .MTxClk          (MTxClk),
        .TxReset_n       (TxReset_n),
        .MAC             (MAC),
        .TxFlow          (TxFlow),
        .TxPauseRq       (TxPauseRq),
        .TxPauseTV       (TxPauseTV),
        .DataFrameActive (DataFrameActive),
        .TxUsedData      (TxUsedData),
        .TxDoneIn        (TxDoneIn),
        .TxAbortIn       (TxAbortIn),
        .CtrlMux         (CtrlMux),
        .TxCtrlStartFrm  (TxCtrlStartFrm),
        .TxCtrlEndFrm    (TxCtrlEndFrm),
        .TxCtrlData      (TxCtrlData),
        .CtrlTxDone      (CtrlTxDone),
        .PauseRqBusy     (PauseRqBusy)
    );

    always #5 MTxClk = ~MTxClk;

    int checks = 0;
    int errors = 0;

    // Model of the pending request slot: whether one is queued and its pause time
    bit          mPend = 1'b0;
    logic [15:0] mTV   = 16'h0000;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkI(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected frame byte: fixed header image as one vector, zero pad beyond it
    function automatic logic [7:0] expByte(input int idx, input logic [15:0] tv, input logic [47:0] mac);
        logic [143:0] hdr;
        hdr = {48'h0180C2000001, mac, 16'h8808, 16'h0001, tv};
        if (idx < 18) return hdr[143 - 8*idx -: 8];
        return 8'h00;
    endfunction

    task automatic tick();
        @(negedge MTxClk);
    endtask

    task automatic request(input logic [15:0] tv, input bit flow);
        TxPauseRq = 1'b1;
        TxPauseTV = tv;
        TxFlow    = flow;
        tick();
        TxPauseRq = 1'b0;
        TxFlow    = 1'b1;
        if (flow) begin
            mPend = 1'b1;
            mTV   = tv;
        end
    endtask

    task automatic waitStart(input string tag, input int budget);
        int waited;
        waited = 0;
        while (CtrlMux !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        chk1(tag, CtrlMux, 1'b1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        chk1({tag, "_mux"},   CtrlMux, 1'b0);
        chk1({tag, "_sof"},   TxCtrlStartFrm, 1'b0);
        chk1({tag, "_eof"},   TxCtrlEndFrm, 1'b0);
        chk8({tag, "_data"},  TxCtrlData, 8'h00);
        chk1({tag, "_done"},  CtrlTxDone, 1'b0);
        chk1({tag, "_busy"},  PauseRqBusy, 1'b0);
    endtask

    // Called at the first cycle of START; walks the frame as the MAC would and checks every byte
    task automatic sendFrame(input logic [15:0] tv, input bit randUsed, input int abortAt,
                             input int rqAt, input logic [15:0] rqTV, input bit endAbort);
        int idx;
        int guard;
        bit used;
        bit rqSent;
        idx    = 0;
        guard  = 0;
        rqSent = 1'b0;
        mPend  = 1'b0;
        while (idx < FRM_LEN && guard < 4000) begin
            guard++;
            chk1("frm_mux", CtrlMux, 1'b1);
            chk1("frm_sof", TxCtrlStartFrm, idx == 0);
            chk1("frm_eof", TxCtrlEndFrm, idx == FRM_LEN - 1);
            chk8($sformatf("frm_byte%0d", idx), TxCtrlData, expByte(idx, tv, MAC));
            chk1("frm_busy", PauseRqBusy, 1'b1);
            if (idx == abortAt) begin
                TxUsedData = 1'b0;
                TxAbortIn  = 1'b1;
                tick();
                TxAbortIn       = 1'b0;
                TxFlow          = 1'b1;
                DataFrameActive = 1'b0;
                chk1("abort_mux",  CtrlMux, 1'b0);
                chk1("abort_done", CtrlTxDone, 1'b0);
                chk1("abort_busy", PauseRqBusy, mPend);
                return;
            end
            used = randUsed ? 1'($urandom_range(0, 1)) : 1'b1;
            TxUsedData = used;
            if (randUsed) begin
                TxFlow          = 1'($urandom_range(0, 1));
                DataFrameActive = 1'($urandom_range(0, 1));
            end
            if (idx == rqAt && !rqSent) begin
                rqSent    = 1'b1;
                TxPauseRq = 1'b1;
                TxPauseTV = rqTV;
                TxFlow    = 1'b1;
                mPend     = 1'b1;
                mTV       = rqTV;
            end
            tick();
            TxPauseRq = 1'b0;
            if (used) idx++;
        end
        chkI("frm_len", idx, FRM_LEN);
        TxUsedData      = 1'b0;
        TxFlow          = 1'b1;
        DataFrameActive = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            chk1("done_mux",   CtrlMux, 1'b1);
            chk8("done_data",  TxCtrlData, 8'h00);
            chk1("done_eof",   TxCtrlEndFrm, 1'b0);
            chk1("done_early", CtrlTxDone, 1'b0);
            tick();
        end
        if (endAbort) TxAbortIn = 1'b1;
        else          TxDoneIn  = 1'b1;
        tick();
        TxAbortIn = 1'b0;
        TxDoneIn  = 1'b0;
        chk1("exit_pulse", CtrlTxDone, !endAbort);
        chk1("exit_mux",   CtrlMux, 1'b0);
        chk1("exit_busy",  PauseRqBusy, mPend);
        tick();
        chk1("pulse_len",  CtrlTxDone, 1'b0);
        chk1("b2b_start",  CtrlMux, mPend);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        TxReset_n       = 1'b0;
        MAC             = 48'h0011_2233_4455;
        TxFlow          = 1'b1;
        TxPauseRq       = 1'b0;
        TxPauseTV       = 16'h0000;
        DataFrameActive = 1'b0;
        TxUsedData      = 1'b0;
        TxDoneIn        = 1'b0;
        TxAbortIn       = 1'b0;
        tick();
        tick();
        checkIdleOutputs("rst");
        TxReset_n = 1'b1;
        tick();
        checkIdleOutputs("post_rst");

        // Basic frame with continuous consumption, checking launch latency
        request(16'h1234, 1'b1);
        chk1("t1_wait_mux", CtrlMux, 1'b0);
        chk1("t1_wait_busy", PauseRqBusy, 1'b1);
        tick();
        chk1("t1_launch", CtrlMux, 1'b1);
        sendFrame(16'h1234, 1'b0, -1, -1, 16'h0000, 1'b0);
        chk1("t1_idle_busy", PauseRqBusy, 1'b0);

        // Request held off by an active data frame
        DataFrameActive = 1'b1;
        request(16'h0ABC, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk1("t2_hold_mux", CtrlMux, 1'b0);
            chk1("t2_hold_busy", PauseRqBusy, 1'b1);
            tick();
        end
        DataFrameActive = 1'b0;
        tick();
        chk1("t2_launch", CtrlMux, 1'b1);
        sendFrame(16'h0ABC, 1'b0, -1, -1, 16'h0000, 1'b0);

        // Two queued requests collapse into one frame carrying the later value
        DataFrameActive = 1'b1;
        request(16'h0010, 1'b1);
        tick();
        request(16'h0020, 1'b1);
        repeat (3) tick();
        DataFrameActive = 1'b0;
        tick();
        chk1("t3_launch", CtrlMux, 1'b1);
        sendFrame(16'h0020, 1'b0, -1, -1, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk1("t3_single", CtrlMux, 1'b0);
            tick();
        end

        // Request during SEND: current frame unchanged, second frame follows back to back
        request(16'h1234, 1'b1);
        tick();
        chk1("t4_launch", CtrlMux, 1'b1);
        sendFrame(16'h1234, 1'b1, -1, 20, 16'h00FF, 1'b0);
        sendFrame(16'h00FF, 1'b0, -1, -1, 16'h0000, 1'b0);

        // Abort at byte 30
        request(16'h5A5A, 1'b1);
        tick();
        chk1("t5_launch", CtrlMux, 1'b1);
        sendFrame(16'h5A5A, 1'b0, 30, -1, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t5_stay_idle", CtrlMux, 1'b0);
            chk1("t5_no_pulse", CtrlTxDone, 1'b0);
        end

        // Asynchronous reset in the middle of SEND with a request pending
        request(16'h7777, 1'b1);
        tick();
        chk1("t6_launch", CtrlMux, 1'b1);
        mPend = 1'b0;
        TxUsedData = 1'b1;
        repeat (10) tick();
        request(16'h4321, 1'b1);
        #2;
        TxReset_n = 1'b0;
        #1;
        checkIdleOutputs("t6_async");
        tick();
        TxReset_n  = 1'b1;
        TxUsedData = 1'b0;
        mPend      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("t6_pend_cleared", PauseRqBusy, 1'b0);
            chk1("t6_no_frame", CtrlMux, 1'b0);
        end
        request(16'h9999, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk1("t6_flow_off_busy", PauseRqBusy, 1'b0);
            chk1("t6_flow_off_mux", CtrlMux, 1'b0);
            tick();
        end

        // Randomized frames: random MAC, pause time, pacing, hold-off, ending
        for (int n = 0; n < 10; n++) begin
            logic [15:0] tv;
            int abortAt;
            MAC             = {16'($urandom()), $urandom()};
            tv              = 16'($urandom());
            DataFrameActive = 1'($urandom_range(0, 1));
            request(tv, 1'b1);
            repeat ($urandom_range(0, 4)) tick();
            DataFrameActive = 1'b0;
            waitStart("rnd_start", 6);
            abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRM_LEN - 1)) : -1;
            sendFrame(tv, 1'b1, abortAt, -1, 16'h0000, $urandom_range(0, 3) == 0);
            tick();
            chk1("rnd_idle_busy", PauseRqBusy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
